// File: rtl/nrisc_pc_unit.sv
// Program counter and next-PC sequencer for the 8-bit nRisc core.
// Owns the fetch address, the halt state and a saturating retired-instruction counter.
module nrisc_pc_unit #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic                 i_pAND,
  input  logic [PC_WIDTH-1:0]  i_branch_target,
  input  logic                 i_jump_en,
  input  logic [PC_WIDTH-1:0]  i_jump_target,
  input  logic                 i_halt_req,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic [PC_WIDTH-1:0]  o_pc_plus1,
  output logic                 o_fetch_valid,
  output logic                 o_halted,
  output logic                 o_wrapped,
  output logic [CNT_WIDTH-1:0] o_retired
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic                 r_fetch_valid;
  logic                 r_halted;
  logic                 r_wrapped;
  logic [CNT_WIDTH-1:0] r_retired;

  logic [PC_WIDTH-1:0]  w_pc_plus1;
  logic [CNT_WIDTH-1:0] w_retired_next;

  assign w_pc_plus1     = r_pc + PC_WIDTH'(1);
  // The counter sticks at all-ones instead of rolling over.
  assign w_retired_next = (&r_retired) ? r_retired : r_retired + CNT_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_wrapped     <= 1'b0;
      r_retired     <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!i_stall) begin
            r_retired <= w_retired_next;
            if (i_halt_req) begin
              r_state       <= ST_HALT;
              r_halted      <= 1'b1;
              r_fetch_valid <= 1'b0;
            end else if (i_jump_en) begin
              r_pc <= i_jump_target;
            end else if (i_pAND) begin
              r_pc <= i_branch_target;
            end else begin
              // Only a sequential step off all-ones counts as a wrap.
              r_pc <= w_pc_plus1;
              if (&r_pc) r_wrapped <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state       <= ST_BOOT;
          r_fetch_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus1    = w_pc_plus1;
  assign o_fetch_valid = r_fetch_valid;
  assign o_halted      = r_halted;
  assign o_wrapped     = r_wrapped;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_nrisc_pc_unit.sv
// Scoreboard bench for nrisc_pc_unit: directed plan then random traffic against a behavioural model.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_nrisc_pc_unit;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       pAND;
  logic [7:0] branch_target;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       halt_req;

  logic [7:0]  pc, pc_plus1;
  logic        fetch_valid, halted, wrapped;
  logic [15:0] retired;

  logic [7:0]  pcB, pc_plus1B;
  logic        fetch_validB, haltedB, wrappedB;
  logic [1:0]  retiredB;

  nrisc_pc_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'h00), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_pAND(pAND),
    .i_branch_target(branch_target), .i_jump_en(jump_en),
    .i_jump_target(jump_target), .i_halt_req(halt_req),
    .o_pc(pc), .o_pc_plus1(pc_plus1), .o_fetch_valid(fetch_valid),
    .o_halted(halted), .o_wrapped(wrapped), .o_retired(retired)
  );

  nrisc_pc_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'h00), .CNT_WIDTH(2)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_pAND(pAND),
    .i_branch_target(branch_target), .i_jump_en(jump_en),
    .i_jump_target(jump_target), .i_halt_req(halt_req),
    .o_pc(pcB), .o_pc_plus1(pc_plus1B), .o_fetch_valid(fetch_validB),
    .o_halted(haltedB), .o_wrapped(wrappedB), .o_retired(retiredB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int fv;
    int hlt;
    int wrp;
    int ret;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: mode 0 = boot, 1 = running, 2 = halted; retired is an unbounded count.
  int mMode = 0;
  int mPc   = 0;
  int mWrap = 0;
  int mRet  = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit st, input bit pa, input int bt,
                               input bit je, input int jt, input bit hr);
    exp_t e;
    rst_n         = r;
    stall         = st;
    pAND          = pa;
    branch_target = 8'(bt);
    jump_en       = je;
    jump_target   = 8'(jt);
    halt_req      = hr;
    if (!r) begin
      mMode = 0; mPc = 0; mWrap = 0; mRet = 0;
    end else if (mMode == 0) begin
      mMode = 1;
    end else if (mMode == 1 && !st) begin
      mRet++;
      if (hr)      mMode = 2;
      else if (je) mPc = jt % 256;
      else if (pa) mPc = bt % 256;
      else begin
        if (mPc == 255) mWrap = 1;
        mPc = (mPc + 1) % 256;
      end
    end
    e.pc  = mPc;
    e.fv  = (mMode == 1) ? 1 : 0;
    e.hlt = (mMode == 2) ? 1 : 0;
    e.wrp = mWrap;
    e.ret = mRet;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic runSeq(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every posedge the registered outputs change, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc",           int'(pc),           e.pc);
        checkOutput("pc_plus1",     int'(pc_plus1),     (e.pc + 1) % 256);
        checkOutput("fetch_valid",  int'(fetch_valid),  e.fv);
        checkOutput("halted",       int'(halted),       e.hlt);
        checkOutput("wrapped",      int'(wrapped),      e.wrp);
        checkOutput("retired",      int'(retired),      (e.ret > 65535) ? 65535 : e.ret);
        checkOutput("pcB",          int'(pcB),          e.pc);
        checkOutput("pc_plus1B",    int'(pc_plus1B),    (e.pc + 1) % 256);
        checkOutput("fetch_validB", int'(fetch_validB), e.fv);
        checkOutput("haltedB",      int'(haltedB),      e.hlt);
        checkOutput("wrappedB",     int'(wrappedB),     e.wrp);
        checkOutput("retired_sat",  int'(retiredB),     (e.ret > 3) ? 3 : e.ret);
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; pAND = 1'b0; branch_target = '0;
    jump_en = 1'b0; jump_target = '0; halt_req = 1'b0;
    @(negedge clk);

    // Reset then free-run.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    runSeq(5);

    // Branch select and jump-over-branch priority.
    applyStimulus(1, 0, 0, 0, 1, 'h11, 0);
    applyStimulus(1, 0, 1, 'h0D, 0, 0, 0);
    applyStimulus(1, 0, 0, 'h0D, 0, 0, 0);
    applyStimulus(1, 0, 1, 'h0D, 1, 'h40, 0);

    // Stall holds pc and retired even with a branch pending.
    applyStimulus(1, 0, 0, 0, 1, 'h05, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 'h77, 1, 'h55, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Wrap on sequential step; then a jump to zero after reset must not set it.
    applyStimulus(1, 0, 0, 0, 1, 'hFF, 0);
    runSeq(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 'h00, 0);
    applyStimulus(1, 0, 1, 'h00, 0, 0, 0);

    // Halt, then everything but reset is ignored.
    applyStimulus(1, 0, 0, 0, 1, 'h07, 0);
    applyStimulus(1, 0, 1, 'h30, 1, 'h50, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 'h30, 1, 'h20, 0);

    // Reset during halt, then during a stall.
    applyStimulus(0, 0, 0, 0, 1, 'h20, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    runSeq(3);
    applyStimulus(0, 1, 1, 'h44, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, st, pa, je, hr;
      int bt, jt;
      r  = ($urandom_range(0, 39) != 0);
      st = ($urandom_range(0, 3) == 0);
      pa = ($urandom_range(0, 3) == 0);
      je = ($urandom_range(0, 5) == 0);
      hr = ($urandom_range(0, 49) == 0);
      bt = ($urandom_range(0, 7) == 0) ? 'hFF : int'($urandom_range(0, 255));
      jt = ($urandom_range(0, 3) == 0) ? 'hFF : int'($urandom_range(0, 255));
      applyStimulus(r, st, pa, bt, je, jt, hr);
    end

    rst_n = 1'b1; stall = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
